// File: rtl/coin_pkg.sv
// Shared coin definitions for the vending coin interface: one-hot coin codes,
// denomination values in nickels and the payout state encoding.
package coin_pkg;

    localparam int unsigned NUM_DENOM = 5;

    localparam logic [4:0] NICKEL  = 5'b00001;
    localparam logic [4:0] DIME    = 5'b00010;
    localparam logic [4:0] QUARTER = 5'b00100;
    localparam logic [4:0] HALFD   = 5'b01000;
    localparam logic [4:0] FULLD   = 5'b10000;

    typedef enum logic [1:0] {IDLE, PLAN, DISPENSE, DONE} state_t;

    function automatic logic [4:0] denom_val(input logic [2:0] d);
        case (d)
            3'd4:    return 5'd20;
            3'd3:    return 5'd10;
            3'd2:    return 5'd5;
            3'd1:    return 5'd2;
            default: return 5'd1;
        endcase
    endfunction

    function automatic logic [4:0] idx_onehot(input logic [2:0] d);
        case (d)
            3'd4:    return FULLD;
            3'd3:    return HALFD;
            3'd2:    return QUARTER;
            3'd1:    return DIME;
            default: return NICKEL;
        endcase
    endfunction

    // Index of the highest set bit; 0 when nothing is set.
    function automatic logic [2:0] top_idx(input logic [4:0] nz);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (nz[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/coin_take_calc.sv
// One greedy planning step: how many coins of one denomination to take from the
// remaining amount, bounded by inventory, and what is left afterwards.
module coin_take_calc #(
    parameter int unsigned AMT_W = 6,
    parameter int unsigned INV_W = 6,
    parameter int unsigned VAL_W = 5
) (
    input  logic [AMT_W-1:0] rem,
    input  logic [VAL_W-1:0] val,
    input  logic [INV_W-1:0] inv,
    output logic [INV_W-1:0] take,
    output logic [AMT_W-1:0] new_rem
);

    localparam int unsigned W = AMT_W + INV_W;

    logic [W-1:0] quot;
    logic [W-1:0] paid;

    always_comb begin
        quot    = W'(rem) / W'(val);
        take    = (quot < W'(inv)) ? INV_W'(quot) : inv;
        paid    = W'(take) * W'(val);
        new_rem = AMT_W'(W'(rem) - paid);
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout: plans a greedy coin breakdown against local inventory, then
// emits coins one at a time, or refuses the whole request if it cannot pay exactly.
module change_dispenser import coin_pkg::*; #(
    parameter int unsigned AMT_W = 6,
    parameter int unsigned INV_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    input  logic             load_en,
    input  logic [4:0]       load_sel,
    input  logic [INV_W-1:0] load_count,
    output logic [4:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ready,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] short_amount,
    output logic [4:0]       inv_avail
);

    state_t           state;
    logic [2:0]       d;
    logic [2:0]       cur;
    logic [AMT_W-1:0] rem;
    logic [INV_W-1:0] inv  [NUM_DENOM];
    logic [INV_W-1:0] plan [NUM_DENOM];

    logic [INV_W-1:0] take;
    logic [AMT_W-1:0] new_rem;
    logic [4:0]       nz;
    logic [4:0]       nz_plan;
    logic [4:0]       nz_next;

    coin_take_calc #(
        .AMT_W (AMT_W),
        .INV_W (INV_W),
        .VAL_W (5)
    ) u_take_calc (
        .rem     (rem),
        .val     (denom_val(d)),
        .inv     (inv[d]),
        .take    (take),
        .new_rem (new_rem)
    );

    always_comb begin
        nz        = '0;
        inv_avail = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            nz[i]        = (plan[i] != '0);
            inv_avail[i] = (inv[i] != '0);
        end
        // plan[0] is being written on the last planning cycle, so use its new value.
        nz_plan   = {nz[4:1], (take != '0)};
        nz_next   = (plan[cur] == INV_W'(1)) ? (nz & ~coin_out) : nz;
        req_ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            d            <= 3'd0;
            cur          <= 3'd0;
            rem          <= '0;
            coin_out     <= '0;
            coin_valid   <= 1'b0;
            done         <= 1'b0;
            short        <= 1'b0;
            short_amount <= '0;
            for (int i = 0; i < NUM_DENOM; i++) begin
                inv[i]  <= '0;
                plan[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    short        <= 1'b0;
                    short_amount <= '0;
                    if (load_en) begin
                        for (int i = 0; i < NUM_DENOM; i++) begin
                            if (load_sel[i]) inv[i] <= load_count;
                        end
                    end
                    if (req_valid) begin
                        rem   <= req_amount;
                        d     <= 3'd4;
                        state <= PLAN;
                        for (int i = 0; i < NUM_DENOM; i++) plan[i] <= '0;
                    end
                end
                PLAN: begin
                    plan[d] <= take;
                    rem     <= new_rem;
                    if (d != 3'd0) begin
                        d <= d - 3'd1;
                    end else if (new_rem != '0) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        short        <= 1'b1;
                        short_amount <= new_rem;
                    end else if (nz_plan == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= DISPENSE;
                        coin_valid <= 1'b1;
                        cur        <= top_idx(nz_plan);
                        coin_out   <= idx_onehot(top_idx(nz_plan));
                    end
                end
                DISPENSE: begin
                    if (coin_ready) begin
                        plan[cur] <= plan[cur] - INV_W'(1);
                        inv[cur]  <= inv[cur] - INV_W'(1);
                        if (nz_next == '0) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            coin_valid <= 1'b0;
                            coin_out   <= '0;
                        end else begin
                            cur      <= top_idx(nz_next);
                            coin_out <= idx_onehot(top_idx(nz_next));
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    short        <= 1'b0;
                    short_amount <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
